led_mode_ctrl: RTL and testbench

Mode scheduler for the LED bank. Decides which pattern datapath owns the LEDs: the flash pattern (1 LED), the run pattern (3 LEDs), both, or neither. It debounces a user key and, optionally, auto-advances on a dwell timer. It drives the pattern generators' run-enables and gates their outputs onto the LED pins. It sits between the flash/run pattern modules and the top-level LED outputs.

---
 rtl/led_pkg.sv | 37 +++
 rtl/key_debounce.sv | 91 +++++++++
 rtl/led_mode_ctrl.sv | 166 ++++++++++++++++
 tb/tb_led_mode_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// ---------------------------------------------------------------------------
// led_pkg
// Shared definitions for the LED mode scheduler.
//   mode_t            : 2-bit mode code driven onto the Mode pins
//                       (IDLE=0, FLASH=1, RUN=2, MIX=3).
//   FLASH_EN_MAP      : bit N set when mode N enables the flash datapath.
//   RUN_EN_MAP        : bit N set when mode N enables the run datapath.
//   DEFAULT_TICK_DIV  : clock cycles per 1 ms tick for a 50 MHz clock.
//   next_mode()       : advance order IDLE -> FLASH -> RUN -> MIX -> IDLE.
// ---------------------------------------------------------------------------
package led_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLASH = 2'd1,
    RUN   = 2'd2,
    MIX   = 2'd3
  } mode_t;

  // Indexed by the mode code: FLASH and MIX own the flash LED,
  // RUN and MIX own the run LEDs.
  localparam logic [3:0] FLASH_EN_MAP = 4'b1010;
  localparam logic [3:0] RUN_EN_MAP   = 4'b1100;

  localparam int DEFAULT_TICK_DIV = 50000;

  // MIX wraps back to IDLE so the user can always turn the bank off.
  function automatic mode_t next_mode(input mode_t cur);
    case (cur)
      IDLE:    return FLASH;
      FLASH:   return RUN;
      RUN:     return MIX;
      default: return IDLE;
    endcase
  endfunction

endpackage

// File: rtl/key_debounce.sv
// ---------------------------------------------------------------------------
// key_debounce
// Synchronises the raw active-low push-button, filters contact bounce with a
// tick-based counter and emits a single-cycle pulse on each accepted press.
//
// Ports
//   CLK    in  system clock, rising edge
//   RST    in  asynchronous active-high reset
//   tick   in  one-cycle 1 ms strobe from the tick generator
//   Key_In in  raw push-button, active-low, asynchronous to CLK
//   press  out one-cycle pulse, one cycle after the accepted 1->0 flip
// ---------------------------------------------------------------------------
module key_debounce
  import led_pkg::*;
#(
  parameter int DEBOUNCE_MS = 20
) (
  input  logic CLK,
  input  logic RST,
  input  logic tick,
  input  logic Key_In,
  output logic press
);

  localparam int              DB_W    = $clog2(DEBOUNCE_MS + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_MS - 1);

  logic            key_meta;
  logic            key_sync;
  logic            key_level;
  logic            armed;
  logic [DB_W-1:0] db_cnt;

  // Two-flop synchroniser. Both stages reset to the released level so
  // leaving reset never looks like a fresh key edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      key_meta <= 1'b1;
      key_sync <= 1'b1;
    end else begin
      key_meta <= Key_In;
      key_sync <= key_meta;
    end
  end

  // Debounce counter and accepted level.
  //
  // After reset the filter is not armed: it first has to see the key
  // released and stable for DEBOUNCE_MS ticks. A key held down through
  // reset therefore never turns into a press; the user has to let go and
  // press again.
  //
  // Once armed, the counter advances on each tick while the synchronised
  // level disagrees with the accepted one and clears as soon as they agree,
  // so any bounce shorter than DEBOUNCE_MS ticks is discarded. The tick that
  // brings the count to DEBOUNCE_MS flips the accepted level; only a 1->0
  // flip (a press) raises the pulse, release is silent.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      db_cnt    <= '0;
      key_level <= 1'b1;
      armed     <= 1'b0;
      press     <= 1'b0;
    end else begin
      press <= 1'b0;
      if (!armed) begin
        if (!key_sync) begin
          db_cnt <= '0;
        end else if (tick) begin
          if (db_cnt == DB_LAST) begin
            armed  <= 1'b1;
            db_cnt <= '0;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end
      end else if (key_sync == key_level) begin
        db_cnt <= '0;
      end else if (tick) begin
        if (db_cnt == DB_LAST) begin
          key_level <= key_sync;
          db_cnt    <= '0;
          press     <= ~key_sync;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/led_mode_ctrl.sv
// ---------------------------------------------------------------------------
// led_mode_ctrl
// Mode scheduler for the LED bank. Chooses which pattern datapath owns the
// LEDs (none, flash, run, or both), drives the datapaths' run-enables and
// gates their outputs onto the LED pins. Modes advance on a debounced key
// press and, when built with LED_MODE_AUTO_EN, on a dwell timer.
//
// Build option
//   LED_MODE_AUTO_EN defined   : dwell timer present, Auto_En honoured.
//   LED_MODE_AUTO_EN undefined : no dwell logic, Auto_En is ignored and the
//                                mode only changes on key presses.
//
// Parameters
//   TICK_DIV    CLK cycles per 1 ms tick
//   DEBOUNCE_MS ticks the key must be stable before it is accepted
//   DWELL_MS    ticks spent in each mode while auto-advancing (>= 1)
//
// Ports
//   CLK       in  system clock, rising edge
//   RST       in  asynchronous active-high reset
//   Key_In    in  raw push-button, active-low, asynchronous
//   Auto_En   in  1 = auto-advance through the modes
//   Flash_In  in  flash pattern datapath output
//   Run_In    in  run pattern datapath output (3 LEDs)
//   Flash_En  out run-enable to the flash datapath
//   Run_En    out run-enable to the run datapath
//   Flash_LED out gated flash LED (registered)
//   Run_LED   out gated run LEDs (registered)
//   Mode      out current mode code
//   Mode_Chg  out one-cycle pulse, the cycle after every mode change
// ---------------------------------------------------------------------------
module led_mode_ctrl
  import led_pkg::*;
#(
  parameter int TICK_DIV    = DEFAULT_TICK_DIV,
  parameter int DEBOUNCE_MS = 20,
  parameter int DWELL_MS    = 5000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Key_In,
  input  logic       Auto_En,
  input  logic       Flash_In,
  input  logic [2:0] Run_In,
  output logic       Flash_En,
  output logic       Run_En,
  output logic       Flash_LED,
  output logic [2:0] Run_LED,
  output logic [1:0] Mode,
  output logic       Mode_Chg
);

  localparam int                TICK_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  logic [TICK_W-1:0] tick_cnt;
  logic              tick;
  logic              press;
  logic              dwell_exp;
  logic              advance;
  mode_t             mode_q;
  mode_t             mode_d;
  logic              flash_en;
  logic              run_en;

  // Free-running millisecond tick: the counter wraps at TICK_DIV-1 and the
  // strobe is high for exactly that one cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  assign tick = (tick_cnt == TICK_LAST);

  key_debounce #(
    .DEBOUNCE_MS(DEBOUNCE_MS)
  ) u_key_debounce (
    .CLK   (CLK),
    .RST   (RST),
    .tick  (tick),
    .Key_In(Key_In),
    .press (press)
  );

  // A press and a dwell expiry arriving together still give a single step,
  // because both simply feed one advance strobe.
  assign advance = press | dwell_exp;

`ifdef LED_MODE_AUTO_EN
  localparam int              DW_W    = $clog2(DWELL_MS + 1);
  localparam logic [DW_W-1:0] DW_LAST = DW_W'(DWELL_MS - 1);

  logic [DW_W-1:0] dwell_cnt;

  // Dwell timer. Counts ticks while auto-advance is enabled and restarts on
  // every advance (key or timer) and whenever Auto_En drops. The expiry is
  // registered, so it lines up with the registered key press and the two can
  // meet in the same cycle. An advance already happening this cycle restarts
  // the dwell, so it suppresses a coincident expiry.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dwell_cnt <= '0;
      dwell_exp <= 1'b0;
    end else begin
      dwell_exp <= Auto_En && tick && (dwell_cnt == DW_LAST) && !advance;
      if (!Auto_En || advance) begin
        dwell_cnt <= '0;
      end else if (tick) begin
        dwell_cnt <= (dwell_cnt == DW_LAST) ? '0 : dwell_cnt + 1'b1;
      end
    end
  end
`else
  logic unused_auto_cfg;

  // Without the dwell timer the mode only moves on key presses. Auto_En and
  // DWELL_MS stay in the interface so both builds share one port list.
  assign dwell_exp       = 1'b0;
  assign unused_auto_cfg = Auto_En | (DWELL_MS < 1);
`endif

  // Mode state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mode_q <= IDLE;
    end else begin
      mode_q <= mode_d;
    end
  end

  // Next-mode and enable decode. The enables come straight from the current
  // mode, so they change on the same edge as Mode.
  always_comb begin
    mode_d   = mode_q;
    flash_en = FLASH_EN_MAP[mode_q];
    run_en   = RUN_EN_MAP[mode_q];
    if (advance) begin
      mode_d = next_mode(mode_q);
    end
  end

  // Registered outputs: Mode_Chg marks the cycle after each advance, and the
  // LED pins carry the datapath outputs masked by the previous cycle's
  // enables, so a disabled datapath always shows dark.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      Mode_Chg  <= 1'b0;
      Flash_LED <= 1'b0;
      Run_LED   <= 3'b000;
    end else begin
      Mode_Chg  <= advance;
      Flash_LED <= Flash_In & flash_en;
      Run_LED   <= Run_In & {3{run_en}};
    end
  end

  assign Flash_En = flash_en;
  assign Run_En   = run_en;
  assign Mode     = mode_q;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// ---------------------------------------------------------------------------
// tb_led_mode_ctrl
// Directed bench for led_mode_ctrl with TICK_DIV=4, DEBOUNCE_MS=3,
// DWELL_MS=5 (one tick every 4 cycles, auto-advance every 20 cycles).
// Inputs are driven and outputs sampled on the falling clock edge.
// The auto-advance section depends on LED_MODE_AUTO_EN.
// ---------------------------------------------------------------------------
module tb_led_mode_ctrl;

  localparam int TICK_DIV    = 4;
  localparam int DEBOUNCE_MS = 3;
  localparam int DWELL_MS    = 5;

  logic       CLK = 1'b0;
  logic       RST;
  logic       Key_In;
  logic       Auto_En;
  logic       Flash_In;
  logic [2:0] Run_In;
  logic       Flash_En;
  logic       Run_En;
  logic       Flash_LED;
  logic [2:0] Run_LED;
  logic [1:0] Mode;
  logic       Mode_Chg;

  int check_count = 0;
  int error_count = 0;
  int cycle_num   = 0;
  int chg_count   = 0;

  led_mode_ctrl #(
    .TICK_DIV   (TICK_DIV),
    .DEBOUNCE_MS(DEBOUNCE_MS),
    .DWELL_MS   (DWELL_MS)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .Key_In   (Key_In),
    .Auto_En  (Auto_En),
    .Flash_In (Flash_In),
    .Run_In   (Run_In),
    .Flash_En (Flash_En),
    .Run_En   (Run_En),
    .Flash_LED(Flash_LED),
    .Run_LED  (Run_LED),
    .Mode     (Mode),
    .Mode_Chg (Mode_Chg)
  );

  always #5 CLK = ~CLK;

  // Safety net so the run can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    assert (observed === expected)
    else begin
      error_count++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Advance n falling edges, counting Mode_Chg pulses seen on the way.
  task automatic step_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      cycle_num++;
      if (Mode_Chg === 1'b1) chg_count++;
    end
  endtask

  task automatic applyStimulus(input logic key, input logic auto_en, input logic flash,
                               input logic [2:0] run, input int n);
    Key_In   = key;
    Auto_En  = auto_en;
    Flash_In = flash;
    Run_In   = run;
    step_cycles(n);
  endtask

  // Wait (bounded) for the next Mode_Chg pulse; at_cycle = -1 on timeout.
  task automatic wait_chg(input int limit, output int at_cycle);
    at_cycle = -1;
    for (int n = 0; n < limit; n++) begin
      step_cycles(1);
      if (Mode_Chg === 1'b1) begin
        at_cycle = cycle_num;
        break;
      end
    end
  endtask

  initial begin
    int exp_mode;
    int exp_flash;
    int exp_run;
    int t0, t1, t2, t3, t4;

    // ---------------- reset with key held down ----------------
    RST      = 1'b1;
    Key_In   = 1'b0;
    Auto_En  = 1'b0;
    Flash_In = 1'b1;
    Run_In   = 3'b111;
    step_cycles(3);
    checkOutput("rst_mode",      Mode,      0);
    checkOutput("rst_flash_en",  Flash_En,  0);
    checkOutput("rst_run_en",    Run_En,    0);
    checkOutput("rst_flash_led", Flash_LED, 0);
    checkOutput("rst_run_led",   Run_LED,   0);
    checkOutput("rst_mode_chg",  Mode_Chg,  0);

    RST       = 1'b0;
    chg_count = 0;
    applyStimulus(1'b0, 1'b0, 1'b1, 3'b111, 100);
    checkOutput("held_key_chg",   chg_count, 0);
    checkOutput("held_key_mode",  Mode,      0);
    checkOutput("held_key_led",   Flash_LED, 0);

    chg_count = 0;
    applyStimulus(1'b1, 1'b0, 1'b1, 3'b111, 30);
    checkOutput("held_release_chg", chg_count, 0);

    // ---------------- clean press ----------------
    chg_count = 0;
    applyStimulus(1'b0, 1'b0, 1'b1, 3'b111, 40);
    checkOutput("press_chg",       chg_count, 1);
    checkOutput("press_mode",      Mode,      1);
    checkOutput("press_flash_en",  Flash_En,  1);
    checkOutput("press_run_en",    Run_En,    0);
    checkOutput("press_flash_led", Flash_LED, 1);
    checkOutput("press_run_led",   Run_LED,   0);
    applyStimulus(1'b0, 1'b0, 1'b0, 3'b111, 2);
    checkOutput("flash_follow_low", Flash_LED, 0);
    chg_count = 0;
    applyStimulus(1'b1, 1'b0, 1'b1, 3'b111, 40);
    checkOutput("release_chg", chg_count, 0);

    // ---------------- bounce rejection ----------------
    chg_count = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus((i % 2 == 0) ? 1'b0 : 1'b1, 1'b0, 1'b1, 3'b111, 6);
    end
    applyStimulus(1'b1, 1'b0, 1'b1, 3'b111, 40);
    checkOutput("bounce_chg",  chg_count, 0);
    checkOutput("bounce_mode", Mode,      1);

    // ---------------- full cycle from a fresh reset ----------------
    RST = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b1, 3'b101, 2);
    checkOutput("rst2_mode", Mode, 0);
    RST = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b1, 3'b101, 30);
    exp_mode = 0;
    for (int p = 0; p < 4; p++) begin
      chg_count = 0;
      applyStimulus(1'b0, 1'b0, 1'b1, 3'b101, 40);
      exp_mode  = (exp_mode + 1) % 4;
      exp_flash = (exp_mode == 1 || exp_mode == 3) ? 1 : 0;
      exp_run   = (exp_mode >= 2) ? 1 : 0;
      checkOutput("cycle_mode",      Mode,      exp_mode);
      checkOutput("cycle_flash_en",  Flash_En,  exp_flash);
      checkOutput("cycle_run_en",    Run_En,    exp_run);
      checkOutput("cycle_flash_led", Flash_LED, exp_flash);
      checkOutput("cycle_run_led",   Run_LED,   (exp_run == 1) ? 32'h5 : 32'h0);
      applyStimulus(1'b1, 1'b0, 1'b1, 3'b101, 40);
      checkOutput("cycle_chg", chg_count, 1);
    end

`ifdef LED_MODE_AUTO_EN
    // ---------------- auto-advance ----------------
    Key_In  = 1'b1;
    Auto_En = 1'b1;
    wait_chg(40, t0);
    exp_mode = (exp_mode + 1) % 4;
    checkOutput("auto_first_seen", (t0 >= 0) ? 1 : 0, 1);
    checkOutput("auto_first_mode", Mode, exp_mode);

    wait_chg(40, t1);
    exp_mode = (exp_mode + 1) % 4;
    checkOutput("auto_period", t1 - t0, 20);
    checkOutput("auto_mode",   Mode,    exp_mode);

    // Key pressed so its debounced press lands on the dwell expiry cycle.
    step_cycles(6);
    Key_In = 1'b0;
    wait_chg(40, t2);
    exp_mode = (exp_mode + 1) % 4;
    checkOutput("coincide_time", t2 - t1, 20);
    checkOutput("coincide_mode", Mode,    exp_mode);
    step_cycles(1);
    checkOutput("coincide_single_chg",  Mode_Chg, 0);
    checkOutput("coincide_single_mode", Mode,     exp_mode);

    wait_chg(40, t3);
    exp_mode = (exp_mode + 1) % 4;
    checkOutput("dwell_restart", t3 - t2, 20);
    checkOutput("dwell_restart_mode", Mode, exp_mode);
    Key_In = 1'b1;

    // One low cycle of Auto_En mid-dwell throws away two counted ticks.
    step_cycles(9);
    Auto_En = 1'b0;
    step_cycles(1);
    Auto_En = 1'b1;
    wait_chg(60, t4);
    exp_mode = (exp_mode + 1) % 4;
    checkOutput("auto_clear_time", t4 - t3, 28);
    checkOutput("auto_clear_mode", Mode,    exp_mode);
`else
    // ---------------- Auto_En ignored without the dwell timer ----------------
    chg_count = 0;
    applyStimulus(1'b1, 1'b1, 1'b1, 3'b101, 200);
    checkOutput("noauto_chg",  chg_count, 0);
    checkOutput("noauto_mode", Mode,      exp_mode);
`endif

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
